// File: rtl/ads131_sequencer.sv
// ADS131A0x bring-up and acquisition sequencer: hardware reset, READY poll,
// unlock, register table write, wakeup, lock, then one read frame per DRDY edge.
module ads131_sequencer #(
  parameter int          RST_LOW_CYCLES = 64,
  parameter int          POLL_LIMIT     = 255,
  parameter logic [15:0] READY_WORD     = 16'hFF04,
  parameter int          NUM_REGS       = 4
) (
  input  logic                  system_clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [16*NUM_REGS-1:0] cfg_table,
  input  logic                  drdy_n,
  output logic                  adc_reset_n,
  output logic                  xfer_req,
  output logic [15:0]           xfer_word,
  input  logic                  xfer_ack,
  input  logic [15:0]           xfer_rsp,
  input  logic [95:0]           xfer_ch,
  output logic [95:0]           sample_data,
  output logic                  sample_valid,
  output logic [7:0]            overrun_cnt,
  output logic                  running,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [4:0]            state_dbg
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [15:0] CMD_NULL   = 16'h0000;
  localparam logic [15:0] CMD_UNLOCK = 16'h0655;
  localparam logic [15:0] CMD_WAKEUP = 16'h0033;
  localparam logic [15:0] CMD_LOCK   = 16'h0555;

  typedef enum logic [4:0] {
    S_IDLE = 5'd0, S_RST, S_POLL, S_UNLOCK, S_WREG, S_WAKEUP, S_LOCK, S_RUN, S_READ, S_ERROR
  } state_t;

  state_t        state, state_n;
  logic          phase, phase_n;      // 0: command frame, 1: NULL frame carrying the echo
  logic [15:0]   cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [2:0]    err_n;
  logic          pend, pend_n;        // restart requested while a read is in flight
  logic          issue, capture;
  logic [15:0]   issue_word;
  logic [1:0]    drdy_sync;
  logic          drdy_prev, fall;
  logic [12:0]   entry;
  logic [15:0]   cmd_word, echo;
  logic [2:0]    code;

  assign fall  = drdy_prev & ~drdy_sync[1];
  assign entry = cfg_table[{idx, 4'b0} +: 13];

  always_comb begin
    cmd_word = CMD_NULL;
    echo     = CMD_NULL;
    code     = 3'd0;
    case (state)
      S_UNLOCK: begin cmd_word = CMD_UNLOCK; echo = CMD_UNLOCK; code = 3'd2; end
      S_WREG:   begin cmd_word = {3'b010, entry}; echo = {3'b001, entry}; code = 3'd3; end
      S_WAKEUP: begin cmd_word = CMD_WAKEUP; echo = CMD_WAKEUP; code = 3'd4; end
      S_LOCK:   begin cmd_word = CMD_LOCK; echo = CMD_LOCK; code = 3'd5; end
      default: ;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      cnt          <= '0;
      idx          <= '0;
      pend         <= 1'b0;
      err_code     <= 3'd0;
      xfer_req     <= 1'b0;
      xfer_word    <= 16'h0000;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun_cnt  <= 8'd0;
      drdy_sync    <= 2'b11;
      drdy_prev    <= 1'b1;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      pend     <= pend_n;
      err_code <= err_n;
      if (issue) begin
        xfer_req  <= 1'b1;
        xfer_word <= issue_word;
      end else if (xfer_req && xfer_ack) begin
        xfer_req <= 1'b0;
      end
      sample_valid <= capture;
      if (capture) sample_data <= xfer_ch;
      if (state == S_READ && fall && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      drdy_sync <= {drdy_sync[0], drdy_n};
      drdy_prev <= drdy_sync[1];
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    idx_n      = idx;
    pend_n     = pend;
    err_n      = err_code;
    issue      = 1'b0;
    issue_word = CMD_NULL;
    capture    = 1'b0;
    case (state)
      S_IDLE, S_ERROR:
        if (start) begin state_n = S_RST; cnt_n = '0; err_n = 3'd0; end
      S_RST:
        if (cnt == 16'(RST_LOW_CYCLES - 1)) begin state_n = S_POLL; cnt_n = '0; end
        else cnt_n = cnt + 16'd1;
      S_POLL:
        if (!xfer_req) issue = 1'b1;
        else if (xfer_ack) begin
          if (xfer_rsp == READY_WORD) begin state_n = S_UNLOCK; phase_n = 1'b0; end
          else if (cnt == 16'(POLL_LIMIT - 1)) begin state_n = S_ERROR; err_n = 3'd1; end
          else cnt_n = cnt + 16'd1;
        end
      S_UNLOCK, S_WREG, S_WAKEUP, S_LOCK:
        if (!xfer_req) begin
          issue      = 1'b1;
          issue_word = phase ? CMD_NULL : cmd_word;
        end else if (xfer_ack) begin
          if (!phase) phase_n = 1'b1;
          else if (xfer_rsp != echo) begin state_n = S_ERROR; err_n = code; end
          else begin
            phase_n = 1'b0;
            case (state)
              S_UNLOCK: begin state_n = S_WREG; idx_n = '0; end
              S_WREG:
                if (idx == IW'(NUM_REGS - 1)) begin state_n = S_WAKEUP; idx_n = '0; end
                else idx_n = idx + 1'b1;
              S_WAKEUP: state_n = S_LOCK;
              default:  state_n = S_RUN;
            endcase
          end
        end
      S_RUN:
        if (start) begin state_n = S_RST; cnt_n = '0; err_n = 3'd0; end
        else if (fall) begin state_n = S_READ; issue = 1'b1; end
      S_READ:
        if (xfer_req && xfer_ack) begin
          pend_n = 1'b0;
          if (pend || start) begin state_n = S_RST; cnt_n = '0; err_n = 3'd0; end
          else begin state_n = S_RUN; capture = 1'b1; end
        end else if (start) pend_n = 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    adc_reset_n = (state != S_RST);
    running     = (state == S_RUN) || (state == S_READ);
    error       = (state == S_ERROR);
    state_dbg   = state;
  end
endmodule

// File: tb/tb_ads131_sequencer.sv
// Directed bench: a behavioural ADC/SPI-engine model answers frames; the stimulus
// walks bring-up, acquisition, overrun, error paths and mid-sequence reset.
module tb_ads131_sequencer;
  localparam int LAT = 6;

  logic        clk, reset_n, start, drdy_n, xfer_ack;
  logic [63:0] cfg_table;
  logic [15:0] xfer_rsp, xfer_word;
  logic [95:0] xfer_ch, sample_data;
  logic        adc_reset_n, xfer_req, sample_valid, running, error;
  logic [7:0]  overrun_cnt;
  logic [2:0]  err_code;
  logic [4:0]  state_dbg;

  int tests = 0, fails = 0;
  int ready_at, corrupt_idx, n, base;
  int frames, npoll, wreg_seen, hs_err, sv_cnt = 0;
  logic [15:0] prev_cmd, w, rsp;
  logic        ok, ack_prev, saw_wakeup;
  logic [15:0] log_w [64];

  ads131_sequencer dut (
    .system_clock(clk), .reset_n(reset_n), .start(start), .cfg_table(cfg_table),
    .drdy_n(drdy_n), .adc_reset_n(adc_reset_n), .xfer_req(xfer_req), .xfer_word(xfer_word),
    .xfer_ack(xfer_ack), .xfer_rsp(xfer_rsp), .xfer_ch(xfer_ch), .sample_data(sample_data),
    .sample_valid(sample_valid), .overrun_cnt(overrun_cnt), .running(running), .error(error),
    .err_code(err_code), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [95:0] ch_of(input int k);
    return {24'h100000 + 24'(k), 24'h200000 + 24'(k), 24'h300000 + 24'(k), 24'h400000 + 24'(k)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_running(input int budget);
    for (int i = 0; i < budget && !running; i++) @(negedge clk);
  endtask

  task automatic wait_error(input int budget);
    for (int i = 0; i < budget && !error; i++) @(negedge clk);
  endtask

  task automatic req_quiet(input string tag);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (xfer_req) n++;
    end
    check(tag, n, 0);
  endtask

  task automatic overrun_pair();
    drdy_n = 1'b0; repeat (2) @(negedge clk);
    drdy_n = 1'b1; repeat (2) @(negedge clk);
    drdy_n = 1'b0; repeat (20) @(negedge clk);
    drdy_n = 1'b1; repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) if (sample_valid === 1'b1) sv_cnt++;

  // ADC + SPI engine: each NULL-frame response carries the echo of the previous command
  initial begin
    xfer_ack = 1'b0; xfer_rsp = '0; xfer_ch = '0; frames = 0; npoll = 0; wreg_seen = 0;
    hs_err = 0; prev_cmd = '0; saw_wakeup = 1'b0; ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      xfer_ack = 1'b0;
      if (ack_prev && xfer_req) hs_err++;
      ack_prev = 1'b0;
      if (!adc_reset_n) begin
        frames = 0; npoll = 0; wreg_seen = 0; prev_cmd = '0; saw_wakeup = 1'b0;
      end else if (xfer_req && reset_n) begin
        w = xfer_word; ok = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
          @(negedge clk);
          if (!reset_n || !xfer_req) begin ok = 1'b0; break; end
          if (xfer_word !== w) hs_err++;
        end
        if (ok) begin
          if (prev_cmd == 16'h0655 || prev_cmd == 16'h0033 || prev_cmd == 16'h0555) rsp = prev_cmd;
          else if (prev_cmd[15:13] == 3'b010) begin
            rsp = prev_cmd ^ 16'h6000;
            if (wreg_seen == corrupt_idx) rsp = rsp ^ 16'h0001;
            wreg_seen++;
          end else begin
            npoll++;
            rsp = (ready_at != 0 && npoll >= ready_at) ? 16'hFF04 : 16'h0000;
          end
          if (w == 16'h0033) saw_wakeup = 1'b1;
          if (frames < 64) log_w[frames] = w;
          frames++;
          xfer_rsp = rsp;
          xfer_ch  = ch_of(frames);
          prev_cmd = w;
          xfer_ack = 1'b1;
          ack_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; drdy_n = 1'b1; ready_at = 3; corrupt_idx = -1;
    cfg_table = {16'h2444, 16'h0333, 16'h0222, 16'h0111};
    repeat (3) @(negedge clk);
    check("reset_outputs", {adc_reset_n, xfer_req, xfer_word, sample_valid, overrun_cnt},
          {1'b1, 1'b0, 16'h0, 1'b0, 8'h0});
    check("reset_status", {running, error, err_code, state_dbg}, {1'b0, 1'b0, 3'd0, 5'd0});
    check("reset_sample", sample_data, 96'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // nominal bring-up
    pulse_start();
    check("rst_pulse_low", adc_reset_n, 1'b0);
    n = 0;
    while (!adc_reset_n && n < 300) begin n++; @(negedge clk); end
    check("rst_low_cycles", n, 64);
    check("poll_gap", xfer_req, 1'b0);
    @(negedge clk);
    check("poll_first", {xfer_req, xfer_word}, {1'b1, 16'h0000});
    wait_running(3000);
    check("nom_running", {running, error, state_dbg}, {1'b1, 1'b0, 5'd7});
    check("nom_frames", frames, 17);
    check("nom_words_a", {log_w[3], log_w[5], log_w[7]}, {16'h0655, 16'h4111, 16'h4222});
    check("nom_words_b", {log_w[11], log_w[13], log_w[15]}, {16'h4444, 16'h0033, 16'h0555});

    // acquisition: 10 edges, 200 cycles apart
    base = sv_cnt;
    drdy_n = 1'b0;
    repeat (2) @(negedge clk);
    check("drdy_lat_early", xfer_req, 1'b0);
    @(negedge clk);
    check("drdy_lat", {xfer_req, xfer_word}, {1'b1, 16'h0000});
    repeat (17) @(negedge clk);
    drdy_n = 1'b1;
    repeat (180) @(negedge clk);
    check("acq_data_0", sample_data, ch_of(18));
    for (int e = 1; e < 10; e++) begin
      drdy_n = 1'b0; repeat (20) @(negedge clk);
      drdy_n = 1'b1; repeat (180) @(negedge clk);
      check("acq_data", sample_data, ch_of(18 + e));
    end
    check("acq_valid_cnt", sv_cnt - base, 10);
    check("acq_overrun", overrun_cnt, 8'd0);

    // overrun: second edge while the read is in flight
    base = sv_cnt;
    overrun_pair();
    check("ovr_one_valid", sv_cnt - base, 1);
    check("ovr_cnt_1", overrun_cnt, 8'd1);
    for (int p = 1; p < 300; p++) overrun_pair();
    check("ovr_saturate", overrun_cnt, 8'd255);
    check("ovr_valid_total", sv_cnt - base, 300);

    // restart from RUN; WREG entry 2 echo corrupted
    corrupt_idx = 2;
    pulse_start();
    wait_error(3000);
    check("wreg_err", {error, err_code, state_dbg, running}, {1'b1, 3'd3, 5'd9, 1'b0});
    check("wreg_frames", frames, 11);
    check("wreg_no_wakeup", saw_wakeup, 1'b0);
    req_quiet("wreg_req_idle");

    // READY timeout, restarted from ERROR
    corrupt_idx = -1; ready_at = 0;
    pulse_start();
    check("start_clears_err", {error, err_code}, {1'b0, 3'd0});
    wait_error(6000);
    check("timeout_err", {error, err_code}, {1'b1, 3'd1});
    check("timeout_polls", frames, 255);
    req_quiet("timeout_req_idle");

    // reset during a WREG command frame
    ready_at = 3;
    pulse_start();
    n = 0;
    while (!(xfer_req && xfer_word[15:13] == 3'b010) && n < 3000) begin n++; @(negedge clk); end
    check("midrst_reached", xfer_word[15:13], 3'b010);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {adc_reset_n, xfer_req, xfer_word, sample_valid, overrun_cnt},
          {1'b1, 1'b0, 16'h0, 1'b0, 8'h0});
    check("midrst_status", {running, error, err_code, state_dbg}, {1'b0, 1'b0, 3'd0, 5'd0});
    check("midrst_sample", sample_data, 96'h0);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_running(3000);
    check("rerun_running", {running, error}, {1'b1, 1'b0});
    check("rerun_frames", frames, 17);
    check("handshake", hs_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ads131_sequencer.md
# ads131_sequencer

Power-up, configuration and acquisition sequencer for the ADS131A0x ADC. It sits between the top-level control logic and the SPI frame engine. It pulses the ADC hardware reset, polls for the READY status, unlocks the device and writes a configuration table. It then wakes and locks the ADC and converts every DRDY falling edge into one sample-read frame. All commands are verified against the ADC's echoed response; any mismatch or timeout parks the block in an error state.

## Interface
- RST_LOW_CYCLES, 64: cycles `adc_reset_n` is held low.
- POLL_LIMIT, 255: maximum NULL polls while waiting for READY.
- READY_WORD, 16'hFF04: expected READY status word (A04 variant).
- NUM_REGS, 4: number of configuration table entries.
- system_clock  in  1  system clock (50 MHz).
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins the sequence from IDLE, RUN or ERROR.
- cfg_table  in  16*NUM_REGS  entry i = bits [16i+15:16i] = {addr[7:0], data[7:0]}; entry 0 is written first.
- drdy_n  in  1  ADC data-ready, active low, asynchronous.
- adc_reset_n  out  1  ADC hardware reset.
- xfer_req  out  1  frame request to the SPI engine.
- xfer_word  out  16  command word for the frame.
- xfer_ack  in  1  one-cycle pulse: frame complete, `xfer_rsp` and `xfer_ch` valid.
- xfer_rsp  in  16  first (status) word shifted in during the frame.
- xfer_ch  in  96  four 24-bit channel words from the frame; ch0 occupies [95:72].
- sample_data  out  96  last captured `xfer_ch`.
- sample_valid  out  1  one-cycle pulse when `sample_data` updates.
- overrun_cnt  out  8  saturating count of DRDY edges missed while a read was in flight.
- running  out  1  high in RUN and READ.
- error  out  1  high in ERROR.
- err_code  out  3  1 = READY timeout, 2 = UNLOCK, 3 = WREG, 4 = WAKEUP, 5 = LOCK mismatch.
- state_dbg  out  5  current state encoding.

## Operation
- Commands:
  - NULL 16'h0000
  - UNLOCK 16'h0655
  - WAKEUP 16'h0033
  - LOCK 16'h0555
  - WREG 16'h4000 | (addr[4:0] << 8) | data
- Expected echoes:
  - UNLOCK → 16'h0655; WAKEUP → 16'h0033; LOCK → 16'h0555.
  - WREG → 16'h2000 | (addr[4:0] << 8) | data.
- Every checked command is a command frame followed by a NULL frame. The `xfer_rsp` of the NULL frame is compared with the expected echo. A mismatch moves to ERROR with the matching `err_code`.
- States and transitions:
  - IDLE → RST on `start`.
  - RST: `adc_reset_n` = 0 for RST_LOW_CYCLES, then POLL.
  - POLL: issue NULL frames. `xfer_rsp` == READY_WORD → UNLOCK. After POLL_LIMIT polls with no match → ERROR, code 1.
  - UNLOCK → WREG.
  - WREG: loops i = 0..NUM_REGS-1, then → WAKEUP.
  - WAKEUP → LOCK → RUN.
  - RUN: a DRDY falling edge → READ.
  - READ: issue NULL; on `xfer_ack` capture `xfer_ch` to `sample_data`, pulse `sample_valid`, return to RUN.
  - ERROR: holds until `start`.
- `start` in RUN or ERROR restarts at RST after any outstanding frame is acked. `start` in any other state is ignored.
- `drdy_n` passes through a 2-FF synchronizer plus a falling-edge detector.
- A DRDY edge while in READ increments `overrun_cnt` (saturates at 255). It does not queue a second read.
- Reset values:
  - `adc_reset_n` = 1, `xfer_req` = 0, `xfer_word` = 0.
  - `sample_data` = 0, `sample_valid` = 0, `overrun_cnt` = 0.
  - `running` = 0, `error` = 0, `err_code` = 0, state = IDLE.
- A reset mid-frame abandons the frame immediately. The SPI engine is reset by the same `reset_n`.

## Timing
- Handshake:
  - `xfer_req` and `xfer_word` stay stable from assertion until the `xfer_ack` cycle.
  - `xfer_req` is low the cycle after `xfer_ack`.
  - A new request asserts no earlier than 1 cycle after that.
  - At most one frame is outstanding.
- `start` sampled at edge N → `adc_reset_n` low at N+1, high again at N+1+RST_LOW_CYCLES. The first poll `xfer_req` follows on the next cycle.
- `drdy_n` falls → READ `xfer_req` rises 3 cycles later (2 sync + 1 edge).
- `xfer_ack` at edge N in READ → `sample_valid` high at N+1 for exactly one cycle.
- `error` and `err_code` update the cycle after the mismatching `xfer_ack`. `err_code` clears on the next `start`.
- An `xfer_ack` arriving with `xfer_req` low is ignored.

## Test plan
- Nominal bring-up: model answers READY on the 3rd poll and echoes all commands, NUM_REGS = 4 → exactly 3 + 2*(1+4+1+1) = 17 frames, `running` = 1, `error` = 0.
- READY timeout: model returns 16'h0000 forever → ERROR after exactly 255 polls, `err_code` = 1, `xfer_req` stays low afterwards.
- WREG mismatch: model corrupts the echo of entry 2 → ERROR, `err_code` = 3, no WAKEUP frame issued.
- Acquisition: 10 DRDY falling edges spaced 200 cycles apart → 10 `sample_valid` pulses, `sample_data` equals model channel words, `overrun_cnt` = 0.
- Overrun: a second DRDY edge while the READ frame is in flight → a single `sample_valid` for that pair of edges and `overrun_cnt` = 1. 300 such pairs → `overrun_cnt` saturates at 255.
- Reset mid-sequence: `reset_n` low during the WREG command frame → next cycle all outputs at reset values. `start` afterwards runs the full nominal sequence.
